// File: rtl/small_calc_req_ctrl.sv
// Request front-end for small_calc_CU: debounces the Go button, latches operands/opcode,
// pulses Go, waits for Done (or times out) and captures the result.
module small_calc_req_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             btn_go,
  input  logic [WIDTH-1:0] sw_a,
  input  logic [WIDTH-1:0] sw_b,
  input  logic [1:0]       sw_op,
  input  logic             Done,
  input  logic [WIDTH-1:0] Out,
  output logic             Go,
  output logic [1:0]       Op,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             err,
  output logic [7:0]       req_count
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t         state_q, state_d;
  logic [1:0]     sync_q;
  logic [DBW-1:0] db_cnt;
  logic           db_level;
  logic [TW-1:0]  to_cnt;
  logic           req;
  logic           accept;
  logic           timeout;

  // db_cnt counts consecutive cycles the synced level differs from the accepted one;
  // the request fires in the cycle the new high level is about to be accepted.
  assign req     = sync_q[1] & ~db_level & (db_cnt == DBW'(DB_CYCLES - 1));
  assign accept  = (state_q == IDLE) & req;
  assign timeout = (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q   <= '0;
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_go};
      if (sync_q[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
        db_level <= sync_q[1];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (Done || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign Go   = (state_q == LAUNCH);
  assign busy = (state_q == LAUNCH) || (state_q == WAIT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      A            <= '0;
      B            <= '0;
      Op           <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      req_count    <= '0;
      to_cnt       <= '0;
    end else begin
      if (accept) begin
        A            <= sw_a;
        B            <= sw_b;
        Op           <= sw_op;
        result_valid <= 1'b0;
        err          <= 1'b0;
      end
      if (state_q == LAUNCH) to_cnt <= '0;
      if (state_q == WAIT) begin
        to_cnt <= to_cnt + 1'b1;
        // Done takes priority over a coincident timeout
        if (Done) begin
          result       <= Out;
          result_valid <= 1'b1;
          req_count    <= req_count + 8'd1;
        end else if (timeout) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_small_calc_req_ctrl.sv
// Directed bench for small_calc_req_ctrl with a simple CU model (Done 5 cycles after Go).
module tb_small_calc_req_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       btn_go;
  logic [3:0] sw_a, sw_b;
  logic [1:0] sw_op;
  logic       Done;
  logic [3:0] Out;
  logic       Go;
  logic [1:0] Op;
  logic [3:0] A, B, result;
  logic       result_valid, busy, err;
  logic [7:0] req_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  logic       cu_en = 1'b0;
  logic       cu_done = 1'b0;
  logic       done_force = 1'b0;
  logic [3:0] cu_out = '0;
  int         cu_cnt = 0;
  int         go_total = 0;
  int         go_dbl = 0;
  logic       go_q = 1'b0;

  assign Done = cu_done | done_force;
  assign Out  = cu_out;

  small_calc_req_ctrl #(.WIDTH(4), .DB_CYCLES(4), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .btn_go(btn_go), .sw_a(sw_a), .sw_b(sw_b), .sw_op(sw_op),
    .Done(Done), .Out(Out), .Go(Go), .Op(Op), .A(A), .B(B), .result(result),
    .result_valid(result_valid), .busy(busy), .err(err), .req_count(req_count)
  );

  always #5 CLK = ~CLK;

  // CU model: Done high in the 5th cycle after the Go cycle
  always @(posedge CLK) begin
    if (Go) cu_cnt <= 1;
    else if (cu_cnt != 0 && cu_cnt < 6) cu_cnt <= cu_cnt + 1;
    else cu_cnt <= 0;
    cu_done <= cu_en && (cu_cnt == 4);
    go_q <= Go;
    if (Go) go_total <= go_total + 1;
    if (Go && go_q) go_dbl <= go_dbl + 1;
  end

  typedef struct {
    logic [3:0] a, b;
    logic [1:0] op;
    logic [3:0] outv;
    logic [3:0] exp_a, exp_b;
    logic [1:0] exp_op;
    logic [3:0] exp_res;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press_measure(output int lat);
    btn_go = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!Go && lat < 30);
    chk("go_seen", {31'd0, Go}, 32'd1);
  endtask

  task automatic run_req(input logic [3:0] a, input logic [3:0] outv);
    int lat;
    int n;
    sw_a = a; sw_b = 4'd1; sw_op = 2'd0; cu_out = outv; cu_en = 1'b1;
    press_measure(lat);
    btn_go = 1'b0;
    n = 0;
    while (!result_valid && n < 12) begin
      tick();
      n++;
    end
    chk("run_req_valid", {31'd0, result_valid}, 32'd1);
    exp_cnt = (exp_cnt + 1) % 256;
    tick(); tick();
  endtask

  initial begin
    int lat;
    int g0;

    vecs[0] = '{a: 4'd5,  b: 4'd3,  op: 2'd2, outv: 4'd8,  exp_a: 4'd5,  exp_b: 4'd3,  exp_op: 2'd2, exp_res: 4'd8};
    vecs[1] = '{a: 4'd9,  b: 4'd6,  op: 2'd1, outv: 4'd15, exp_a: 4'd9,  exp_b: 4'd6,  exp_op: 2'd1, exp_res: 4'd15};
    vecs[2] = '{a: 4'd15, b: 4'd15, op: 2'd3, outv: 4'd0,  exp_a: 4'd15, exp_b: 4'd15, exp_op: 2'd3, exp_res: 4'd0};
    vecs[3] = '{a: 4'd0,  b: 4'd1,  op: 2'd0, outv: 4'd1,  exp_a: 4'd0,  exp_b: 4'd1,  exp_op: 2'd0, exp_res: 4'd1};

    RST = 1'b1; btn_go = 1'b0; sw_a = '0; sw_b = '0; sw_op = '0;
    tick(); tick();
    chk("reset_outs", {Go, Op, A, B, result, result_valid, busy, err, req_count}, 32'd0);
    RST = 1'b0;
    tick(); tick();

    // Table-driven clean presses
    for (int i = 0; i < 4; i++) begin
      sw_a = vecs[i].a; sw_b = vecs[i].b; sw_op = vecs[i].op; cu_out = vecs[i].outv; cu_en = 1'b1;
      press_measure(lat);
      chk("press_latency", lat, 6);
      chk("launch_busy", {31'd0, busy}, 32'd1);
      chk("latched_A", A, vecs[i].exp_a);
      chk("latched_B", B, vecs[i].exp_b);
      chk("latched_Op", Op, vecs[i].exp_op);
      btn_go = 1'b0;
      sw_a = ~vecs[i].a; sw_b = ~vecs[i].b; sw_op = ~vecs[i].op;
      tick();
      chk("go_one_cycle", {31'd0, Go}, 32'd0);
      chk("A_held_wait", A, vecs[i].exp_a);
      repeat (4) tick();
      chk("rv_before_done", {31'd0, result_valid}, 32'd0);
      chk("busy_wait", {31'd0, busy}, 32'd1);
      tick();
      exp_cnt++;
      chk("rv_after_done", {31'd0, result_valid}, 32'd1);
      chk("result", result, vecs[i].exp_res);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("req_count", req_count, exp_cnt);
      chk("Op_held_after", Op, vecs[i].exp_op);
      chk("B_held_after", B, vecs[i].exp_b);
      repeat (3) tick();
    end

    // Bouncy press: toggle, then stable; exactly one Go, 2+DB after the final stable edge
    g0 = go_total;
    sw_a = 4'd2; sw_b = 4'd2; sw_op = 2'd1; cu_out = 4'd4;
    repeat (3) begin
      btn_go = 1'b1; tick();
      btn_go = 1'b0; tick();
    end
    press_measure(lat);
    chk("bounce_latency", lat, 6);
    repeat (9) tick();
    btn_go = 1'b0;
    repeat (8) tick();
    exp_cnt++;
    chk("bounce_one_go", go_total - g0, 1);
    chk("bounce_result", result, 4'd4);

    // Glitch shorter than DB_CYCLES: no request
    g0 = go_total;
    btn_go = 1'b1; repeat (3) tick();
    btn_go = 1'b0; repeat (15) tick();
    chk("glitch_no_go", go_total - g0, 0);
    chk("glitch_idle", {31'd0, busy}, 32'd0);

    // Second press and switch change while in WAIT are dropped
    cu_en = 1'b0;
    g0 = go_total;
    sw_a = 4'd5; sw_b = 4'd3; sw_op = 2'd2; cu_out = 4'd8;
    press_measure(lat);
    btn_go = 1'b0;
    repeat (7) tick();
    sw_a = 4'd9; btn_go = 1'b1;
    repeat (7) tick();
    chk("busy_press_wait", {31'd0, busy}, 32'd1);
    done_force = 1'b1; tick(); done_force = 1'b0;
    exp_cnt++;
    chk("drop_A", A, 4'd5);
    chk("drop_result", result, 4'd8);
    chk("drop_rv", {31'd0, result_valid}, 32'd1);
    chk("drop_count", req_count, exp_cnt);
    btn_go = 1'b0;
    repeat (10) tick();
    chk("drop_one_go", go_total - g0, 1);
    chk("drop_idle", {31'd0, busy}, 32'd0);

    // Timeout: Done withheld
    press_measure(lat);
    btn_go = 1'b0;
    repeat (16) tick();
    chk("to_not_yet_err", {31'd0, err}, 32'd0);
    chk("to_not_yet_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_rv", {31'd0, result_valid}, 32'd0);
    chk("to_count", req_count, exp_cnt);
    tick(); tick();
    cu_en = 1'b1;
    press_measure(lat);
    chk("err_cleared", {31'd0, err}, 32'd0);
    btn_go = 1'b0;
    repeat (8) tick();
    exp_cnt++;
    chk("after_to_count", req_count, exp_cnt);

    // Reset mid-WAIT, then stray Done
    cu_en = 1'b0;
    press_measure(lat);
    btn_go = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    #1;
    chk("rst_go_drop", {31'd0, Go}, 32'd0);
    chk("rst_mid_outs", {Go, Op, A, B, result, result_valid, busy, err, req_count}, 32'd0);
    tick();
    RST = 1'b0;
    exp_cnt = 0;
    cu_out = 4'd7; done_force = 1'b1;
    tick(); tick();
    done_force = 1'b0;
    chk("rst_stray_rv", {31'd0, result_valid}, 32'd0);
    chk("rst_stray_cnt", req_count, 32'd0);
    chk("rst_stray_res", result, 32'd0);
    tick(); tick();

    // 256 completions wrap the counter
    for (int i = 0; i < 255; i++) run_req(4'(i), 4'(i + 1));
    chk("count_255", req_count, 32'd255);
    run_req(4'd3, 4'd6);
    chk("count_wrap", req_count, 32'd0);
    chk("wrap_model", req_count, exp_cnt);
    cu_out = 4'd11; done_force = 1'b1;
    tick(); tick();
    done_force = 1'b0;
    chk("idle_done_cnt", req_count, 32'd0);
    chk("idle_done_res", result, 32'd6);
    chk("idle_done_rv", {31'd0, result_valid}, 32'd1);
    chk("go_never_double", go_dbl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
